// File: rtl/writeback_sched.sv
// rtl/writeback_sched.sv - single-port register-file writeback scheduler for ALU results and one outstanding load
module writeback_sched #(
  parameter int Data_Width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  AluValid,
  input  logic [Data_Width-1:0] ALUResult,
  input  logic [4:0]            AluRd,
  input  logic                  LoadIssue,
  input  logic [4:0]            LoadRd,
  input  logic                  MemRespValid,
  input  logic [Data_Width-1:0] ReadData,
  output logic                  Stall,
  output logic                  RegWrite,
  output logic [4:0]            WbRd,
  output logic [Data_Width-1:0] WbData,
  output logic                  ResultSrc,
  output logic                  LoadBusy,
  output logic                  SpurResp
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [4:0]            pend_rd_q, pend_rd_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [4:0]            hold_rd_q, hold_rd_d;
  logic [Data_Width-1:0] hold_data_q, hold_data_d;
  logic                  reg_write_q, reg_write_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [Data_Width-1:0] wb_data_q, wb_data_d;
  logic                  result_src_q, result_src_d;
  logic                  spur_q, spur_d;

  logic in_wait, resp, alu_acc, load_acc, waw_hazard;

  assign in_wait    = (state_q == WAIT);
  assign resp       = in_wait && MemRespValid;
  // An ALU write to the pending load's register must wait until the load data lands.
  assign waw_hazard = in_wait && AluValid && (AluRd == pend_rd_q) && (AluRd != 5'd0) && !MemRespValid;
  assign Stall      = hold_valid_q || (in_wait && LoadIssue && !MemRespValid) || waw_hazard;
  assign alu_acc    = AluValid && !Stall;
  assign load_acc   = LoadIssue && !Stall;

  always_comb begin
    state_d      = state_q;
    pend_rd_d    = pend_rd_q;
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    reg_write_d  = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    result_src_d = result_src_q;
    spur_d       = spur_q || (!in_wait && MemRespValid);

    if (load_acc) begin
      state_d   = WAIT;
      pend_rd_d = LoadRd;
    end else if (resp) begin
      state_d = IDLE;
    end

    if (resp) begin
      wb_data_d    = ReadData;
      wb_rd_d      = pend_rd_q;
      result_src_d = 1'b1;
      reg_write_d  = (pend_rd_q != 5'd0);
      // Load data owns this slot; a same-cycle ALU result is parked for the next one.
      if (alu_acc) begin
        hold_valid_d = 1'b1;
        hold_rd_d    = AluRd;
        hold_data_d  = ALUResult;
      end
    end else if (hold_valid_q) begin
      wb_data_d    = hold_data_q;
      wb_rd_d      = hold_rd_q;
      result_src_d = 1'b0;
      reg_write_d  = (hold_rd_q != 5'd0);
      hold_valid_d = 1'b0;
    end else if (alu_acc) begin
      wb_data_d    = ALUResult;
      wb_rd_d      = AluRd;
      result_src_d = 1'b0;
      reg_write_d  = (AluRd != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_rd_q    <= 5'd0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= 5'd0;
      hold_data_q  <= '0;
      reg_write_q  <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
      result_src_q <= 1'b0;
      spur_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_rd_q    <= pend_rd_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      reg_write_q  <= reg_write_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      result_src_q <= result_src_d;
      spur_q       <= spur_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign WbRd      = wb_rd_q;
  assign WbData    = wb_data_q;
  assign ResultSrc = result_src_q;
  assign LoadBusy  = in_wait;
  assign SpurResp  = spur_q;

endmodule

// File: tb/tb_writeback_sched.sv
// tb/tb_writeback_sched.sv - directed scoreboard bench for writeback_sched
module tb_writeback_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AluValid, LoadIssue, MemRespValid;
  logic [31:0] ALUResult, ReadData;
  logic [4:0]  AluRd, LoadRd;
  logic        Stall, RegWrite, ResultSrc, LoadBusy, SpurResp;
  logic [4:0]  WbRd;
  logic [31:0] WbData;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        src;
  } wr_t;
  wr_t exp_q[$];

  writeback_sched #(.Data_Width(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .AluValid(AluValid), .ALUResult(ALUResult), .AluRd(AluRd),
    .LoadIssue(LoadIssue), .LoadRd(LoadRd),
    .MemRespValid(MemRespValid), .ReadData(ReadData),
    .Stall(Stall), .RegWrite(RegWrite), .WbRd(WbRd), .WbData(WbData),
    .ResultSrc(ResultSrc), .LoadBusy(LoadBusy), .SpurResp(SpurResp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic src);
    wr_t e;
    e.rd = rd; e.data = data; e.src = src;
    exp_q.push_back(e);
  endtask

  // Any register-file write must match the oldest scoreboard entry.
  task automatic monitor();
    wr_t e;
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_rd", {27'd0, WbRd}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, WbRd}, {27'd0, e.rd});
        chk("wb_data", WbData, e.data);
        chk("wb_src", {31'd0, ResultSrc}, {31'd0, e.src});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic idle();
    AluValid = 0; ALUResult = 0; AluRd = 0;
    LoadIssue = 0; LoadRd = 0; MemRespValid = 0; ReadData = 0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    AluValid = 1; AluRd = rd; ALUResult = d;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    LoadIssue = 1; LoadRd = rd;
  endtask

  task automatic drive_resp(input logic [31:0] d);
    MemRespValid = 1; ReadData = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
    chk({tag, "_wbrd"}, {27'd0, WbRd}, 32'd0);
    chk({tag, "_wbdata"}, WbData, 32'd0);
    chk({tag, "_src"}, {31'd0, ResultSrc}, 32'd0);
    chk({tag, "_busy"}, {31'd0, LoadBusy}, 32'd0);
    chk({tag, "_spur"}, {31'd0, SpurResp}, 32'd0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk_all_zero("reset");
    chk("reset_stall", {31'd0, Stall}, 32'd0);
    rst_n = 1;
    step();

    // back-to-back ALU
    drive_alu(5'd5, 32'h11); #1;
    chk("b2b_stall0", {31'd0, Stall}, 32'd0);
    push(5'd5, 32'h11, 1'b0);
    step();
    chk("b2b_we0", {31'd0, RegWrite}, 32'd1);
    drive_alu(5'd6, 32'h22); #1;
    chk("b2b_stall1", {31'd0, Stall}, 32'd0);
    push(5'd6, 32'h22, 1'b0);
    step();
    chk("b2b_we1", {31'd0, RegWrite}, 32'd1);
    idle();
    step();
    chk("b2b_quiet", {31'd0, RegWrite}, 32'd0);

    // load round trip
    drive_load(5'd7); #1;
    chk("ld_stall", {31'd0, Stall}, 32'd0);
    step();
    idle();
    chk("ld_busy1", {31'd0, LoadBusy}, 32'd1);
    step();
    chk("ld_busy2", {31'd0, LoadBusy}, 32'd1);
    step();
    chk("ld_busy3", {31'd0, LoadBusy}, 32'd1);
    drive_resp(32'hDEAD_BEEF);
    push(5'd7, 32'hDEAD_BEEF, 1'b1);
    step();
    idle();
    chk("ld_done_busy", {31'd0, LoadBusy}, 32'd0);
    chk("ld_done_we", {31'd0, RegWrite}, 32'd1);

    // collision of load response and ALU result
    drive_load(5'd7);
    step();
    idle();
    drive_resp(32'hAA); drive_alu(5'd8, 32'hBB); #1;
    chk("col_stall0", {31'd0, Stall}, 32'd0);
    push(5'd7, 32'hAA, 1'b1);
    push(5'd8, 32'hBB, 1'b0);
    step();
    idle(); #1;
    chk("col_stall_hold", {31'd0, Stall}, 32'd1);
    step();
    chk("col_we2", {31'd0, RegWrite}, 32'd1);
    chk("col_stall_after", {31'd0, Stall}, 32'd0);

    // WAW hazard on the pending register
    drive_load(5'd9);
    step();
    idle();
    drive_alu(5'd9, 32'h1); #1;
    chk("waw_stall_c1", {31'd0, Stall}, 32'd1);
    step();
    chk("waw_stall_c2", {31'd0, Stall}, 32'd1);
    step();
    drive_resp(32'h2); #1;
    chk("waw_stall_resp", {31'd0, Stall}, 32'd0);
    push(5'd9, 32'h2, 1'b1);
    push(5'd9, 32'h1, 1'b0);
    step();
    idle();
    step();
    step();

    // x0 write and spurious response
    drive_alu(5'd0, 32'h55);
    step();
    idle();
    chk("x0_we", {31'd0, RegWrite}, 32'd0);
    chk("x0_wbrd", {27'd0, WbRd}, 32'd0);
    chk("x0_wbdata", WbData, 32'h55);
    drive_resp(32'h77);
    step();
    idle();
    chk("spur_we", {31'd0, RegWrite}, 32'd0);
    chk("spur_flag", {31'd0, SpurResp}, 32'd1);
    chk("spur_busy", {31'd0, LoadBusy}, 32'd0);
    chk("spur_wbdata", WbData, 32'h55);
    step();
    chk("spur_sticky", {31'd0, SpurResp}, 32'd1);

    // reset while WAIT with a held ALU entry
    drive_load(5'd10);
    step();
    idle();
    drive_resp(32'h10); drive_alu(5'd11, 32'hB1); drive_load(5'd12); #1;
    chk("rst_setup_stall", {31'd0, Stall}, 32'd0);
    push(5'd10, 32'h10, 1'b1);
    step();
    idle(); #1;
    chk("rst_pre_busy", {31'd0, LoadBusy}, 32'd1);
    chk("rst_pre_hold", {31'd0, Stall}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk_all_zero("rst_async");
    chk("rst_async_stall", {31'd0, Stall}, 32'd0);
    rst_n = 1;
    step();
    chk("rst_post_we", {31'd0, RegWrite}, 32'd0);
    chk("rst_post_busy", {31'd0, LoadBusy}, 32'd0);
    step();
    drive_resp(32'h99);
    step();
    idle();
    chk("rst_late_resp_spur", {31'd0, SpurResp}, 32'd1);
    chk("rst_late_resp_we", {31'd0, RegWrite}, 32'd0);
    step();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_sched.md
WRITEBACK_SCHED -- requirements
Module: writeback_sched

Interface
REQ-001 SHALL have parameter Data_Width, default 32, the width of all result/data buses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port AluValid  input  1  an ALU result is presented this cycle.
REQ-005 SHALL have port ALUResult  input  Data_Width  ALU result value.
REQ-006 SHALL have port AluRd  input  5  destination register of the ALU result.
REQ-007 SHALL have port LoadIssue  input  1  a load is issued to data memory this cycle.
REQ-008 SHALL have port LoadRd  input  5  destination register of the issued load.
REQ-009 SHALL have port MemRespValid  input  1  data memory returns load data this cycle.
REQ-010 SHALL have port ReadData  input  Data_Width  load data from data memory.
REQ-011 SHALL have port Stall  output  1  combinational; when 1, the ALU result and load issue presented this cycle are not accepted.
REQ-012 SHALL have port RegWrite  output  1  registered register-file write enable.
REQ-013 SHALL have port WbRd  output  5  registered write address.
REQ-014 SHALL have port WbData  output  Data_Width  registered write data.
REQ-015 SHALL have port ResultSrc  output  1  registered source of the current write: 1 = load data, 0 = ALU.
REQ-016 SHALL have port LoadBusy  output  1  1 while a load is outstanding (state WAIT).
REQ-017 SHALL have port SpurResp  output  1  sticky flag: MemRespValid was seen in IDLE.

Function
REQ-018 SHALL implement two states:
- IDLE: no load outstanding.
- WAIT: one load outstanding, with its destination held in PendRd.
REQ-019 SHALL, on an accepted LoadIssue, capture LoadRd into PendRd and enter WAIT.
REQ-020 SHALL, on MemRespValid in WAIT, return to IDLE, unless an accepted LoadIssue occurs in the same cycle; then it stays in WAIT with PendRd updated.
REQ-021 SHALL define Stall = HoldValid OR (WAIT AND LoadIssue AND NOT MemRespValid) OR (WAIT AND AluValid AND AluRd==PendRd AND AluRd!=0 AND NOT MemRespValid).
REQ-022 SHALL define an ALU result as accepted when AluValid=1 and Stall=0; a load is accepted when LoadIssue=1 and Stall=0.
REQ-023 SHALL select each cycle's write-port slot in this priority order, with outputs registered at the next edge (latency 1):
- (a) MemRespValid in WAIT -> WbData=ReadData, WbRd=PendRd, ResultSrc=1.
- (b) else HoldValid -> write the held ALU entry with ResultSrc=0, and clear HoldValid.
- (c) else accepted ALU -> WbData=ALUResult, WbRd=AluRd, ResultSrc=0.
- (d) else RegWrite=0, with WbData, WbRd and ResultSrc holding their values.
REQ-024 SHALL, when case (a) coincides with an accepted ALU result, capture ALUResult/AluRd in a one-entry holding buffer and set HoldValid; that entry is written in the next slot.
REQ-025 SHALL drive RegWrite=1 for slots (a)-(c) only when WbRd!=0; a write to x0 consumes the slot with RegWrite=0.
REQ-026 SHALL preserve program order: an ALU result targeting PendRd is never written before the outstanding load's data.
REQ-027 SHALL ignore MemRespValid in IDLE (no write, no state change) and set SpurResp=1 until reset.
REQ-028 SHALL hold LoadBusy=1 exactly in state WAIT.

Reset
REQ-029 SHALL, while rst_n=0, force state IDLE, HoldValid=0, PendRd=0, RegWrite=0, WbRd=0, WbData=0, ResultSrc=0 and SpurResp=0, independent of clk.
REQ-030 SHALL drop an outstanding load and any held ALU entry on reset mid-operation; a later MemRespValid is then treated per REQ-027.

Verification
REQ-031 SHALL cover back-to-back ALU:
- stimulus: AluValid with (x5, 0x11) then (x6, 0x22);
- response: RegWrite on both following cycles, ResultSrc=0, Stall=0 throughout.
REQ-032 SHALL cover load round trip:
- stimulus: LoadIssue with LoadRd=x7; 3 cycles later MemRespValid with ReadData=0xDEADBEEF;
- response: LoadBusy=1 for 3 cycles, then a write to x7 of 0xDEADBEEF with ResultSrc=1.
REQ-033 SHALL cover collision:
- stimulus: MemRespValid (PendRd=x7, 0xAA) in the same cycle as ALU (x8, 0xBB);
- response: cycle+1 writes x7=0xAA with ResultSrc=1; cycle+2 writes x8=0xBB with ResultSrc=0; Stall=1 during cycle+1.
REQ-034 SHALL cover WAW hazard:
- stimulus: in WAIT with PendRd=x9, ALU (x9, 0x1) is presented for 2 cycles, then MemRespValid with 0x2;
- response: Stall=1 for the 2 cycles; writes occur as x9=0x2, then x9=0x1.
REQ-035 SHALL cover x0 and a spurious response:
- stimulus: ALU to x0, then MemRespValid in IDLE;
- response: RegWrite=0 for both; SpurResp=1 and held.
REQ-036 SHALL cover reset mid-load:
- stimulus: rst_n=0 asserted while in WAIT with HoldValid=1;
- response: all outputs 0 asynchronously; after release, LoadBusy=0 and no pending write.
